usb_uart_bridge: RTL and testbench
==================================

# usb_uart_bridge

Byte-stream to UART bridge between the CDC endpoint data ports of `usb_cdc_top` and the board UART pins.
- Host-to-device bytes from the CDC core are serialised onto `uart_tx_o`.
- Frames arriving on `uart_rx_i` are deserialised and presented back to the CDC core as a valid/accept byte stream.
- Runs entirely in the 60 MHz ULPI-derived USB clock domain.

## Interface
Parameters:
- CLK_FREQ, 60000000, clock frequency in Hz
- BAUDRATE, 1000000, UART bit rate; DIV = (CLK_FREQ + BAUDRATE/2) / BAUDRATE, must be ≥ 4
- FIFO_DEPTH, 16, RX FIFO entries, power of two (used only with USB_UART_RXFIFO_EN)

Ports:
- clk_i  in  1  USB clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset
- inport_valid_i  in  1  CDC core has a byte for the UART
- inport_data_i  in  8  byte from CDC core
- inport_accept_o  out  1  bridge takes byte this cycle
- outport_valid_o  out  1  received byte available to CDC core
- outport_data_o  out  8  received byte
- outport_accept_i  in  1  CDC core takes byte this cycle
- uart_tx_o  out  1  UART transmit line, idle high
- uart_rx_i  in  1  UART receive line, asynchronous
- rx_overflow_o  out  1  one-cycle pulse when a received byte is dropped

## Operation
- Frame format is 8N1 and LSB first: start 0, d0..d7, stop 1.
- Each bit lasts DIV cycles.
- TX FSM (IDLE, START, DATA, STOP):
  - `inport_accept_o` = (state==IDLE).
  - On valid&accept, the byte is latched and the FSM moves to START.
  - DATA shifts 8 bits, tracked by a 3-bit index.
  - STOP holds the line high for DIV cycles, then returns to IDLE.
- RX input path: `uart_rx_i` passes through a 2-flop synchroniser (both flops reset to 1).
- RX FSM (IDLE, START, DATA, STOP, WAIT_HIGH):
  - IDLE: a synchronised 1→0 edge enters START with the bit counter cleared.
  - START: sampled at count DIV/2. If 1 (glitch), go to IDLE; if 0, go to DATA.
  - DATA: sample every DIV cycles thereafter, shifting in LSB first.
  - STOP: sampled DIV cycles after d7. If 1, push the byte. If 0 (framing error/break), discard it and go to WAIT_HIGH.
  - WAIT_HIGH: stay until the line is sampled high, then go to IDLE.
- Push into a full buffer: the byte is dropped and `rx_overflow_o` pulses for 1 cycle. Buffer contents are unchanged.
- Full buffer with pop and push in the same cycle: both are performed, no overflow.
- Output handshake: `outport_data_o` is stable while `outport_valid_o` is high and not accepted.
- Reset values: `uart_tx_o`=1, `inport_accept_o`=1 (TX IDLE), `outport_valid_o`=0, `outport_data_o`=0, `rx_overflow_o`=0.
- Reset mid-frame: both FSMs abort to IDLE, the line returns high immediately, and buffered bytes are lost.

## Timing
- TX start: `uart_tx_o` falls in the first cycle after the accept handshake.
- TX frame length: exactly 10·DIV cycles. `inport_accept_o` rises in the cycle after the stop bit ends.
- TX throughput: one byte per 10·DIV+1 cycles.
- RX latency: `uart_rx_i` edge to FSM is 2 cycles (synchroniser).
- RX push: the stop-bit sample cycle pushes, and `outport_valid_o` is high on the next cycle.
- Back-to-back RX frames: a new start edge is detected in IDLE the cycle after the push. This tolerates a sender running up to ~4% faster.
- TX and RX paths are fully independent; concurrent operation is required.

## Configuration
- USB_UART_RXFIFO_EN defined: the RX buffer is a FIFO_DEPTH-entry FIFO with registered output. `outport_valid_o` = not empty.
- Not defined: the RX buffer is a single holding register. A second byte arriving while it is valid is dropped with `rx_overflow_o`.

## Structure
- Package `usb_uart_pkg` holds:
  - the TX and RX state enums
  - the DIV computation function
  - the frame constants: 8 data bits, 1 stop bit
- Sub-module `usb_uart_fifo` (DEPTH, WIDTH=8; push/pop/full/empty) is instantiated only under USB_UART_RXFIFO_EN.

## Test plan
All scenarios use CLK_FREQ=60 MHz and BAUDRATE=1 MHz, giving DIV=60.
- TX byte 0xA5: `uart_tx_o` = 0,1,0,1,0,0,1,0,1,1, each level held 60 cycles. `inport_accept_o` is low for 600 cycles and high on cycle 601.
- RX frame 0x3C driven on `uart_rx_i` → `outport_valid_o` with 0x3C, within 3 cycles of the stop-bit midpoint. The value holds until `outport_accept_i`.
- RX glitch: line low for 20 cycles then high → no byte pushed, FSM back in IDLE.
- RX framing error: 0x55 with stop bit 0, then line held low for 200 cycles → no push. The next valid frame 0x12 is received correctly.
- Overflow, `outport_accept_i`=0:
  - With the macro: 17 frames received; the 17th pulses `rx_overflow_o`, and the first 16 read out in order.
  - Without the macro: the 2nd frame pulses `rx_overflow_o`, and 0x01 (the first byte) remains.
- `rst_n` asserted at TX bit 4 → `uart_tx_o`=1 and `inport_accept_o`=1 during reset. After release, a new 0x0F frame is transmitted cleanly.

Source files
------------

// File: rtl/usb_uart_pkg.sv
// Shared definitions for the USB CDC <-> UART bridge: FSM state encodings,
// 8N1 frame constants and the baud divisor helper.
package usb_uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  // Clock cycles per UART bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baudrate);
    return (clk_freq + baudrate / 2) / baudrate;
  endfunction

endpackage

// File: rtl/usb_uart_fifo.sv
// Small synchronous FIFO used as the RX byte buffer when USB_UART_RXFIFO_EN
// is defined. Head entry is presented on data_o (zero while empty); a push
// into a full FIFO is ignored unless a pop happens in the same cycle.
module usb_uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_wr    = push_i & (~full_o | pop_i);
  assign w_rd    = pop_i & ~empty_o;
  assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  // Storage write; entries are only ever read after being written.
  // NOTE: the memory array has no reset so it maps onto plain registers/RAM;
  // only the pointers and count need a known value.
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= data_i;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/usb_uart_bridge.sv
// Byte-stream <-> 8N1 UART bridge for the USB CDC endpoint, single clock.
// TX serialises accepted bytes; RX oversamples a synchronised line and
// offers received bytes on a valid/accept port.
// Build option: USB_UART_RXFIFO_EN selects a FIFO_DEPTH-entry RX FIFO;
// otherwise the RX buffer is a single holding register.
module usb_uart_bridge
  import usb_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 60000000,
  parameter int unsigned BAUDRATE   = 1000000,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       inport_valid_i,
  input  logic [7:0] inport_data_i,
  output logic       inport_accept_o,
  output logic       outport_valid_o,
  output logic [7:0] outport_data_o,
  input  logic       outport_accept_i,
  output logic       uart_tx_o,
  input  logic       uart_rx_i,
  output logic       rx_overflow_o
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUDRATE);
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(DIV / 2);

  // Elaboration guards on configuration.
  if (DIV < 4) begin : g_bad_div
    $error("usb_uart_bridge: baud divisor must be at least 4");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("usb_uart_bridge: FIFO_DEPTH must be a power of two");
  end

  // ---------------------------------------------------------------- TX path
  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_idx;
  logic [7:0]    r_tx_shift;
  logic          r_tx;
  logic          w_tx_bit_end;

  assign w_tx_bit_end    = (r_tx_cnt == BIT_LAST);
  assign inport_accept_o = (r_tx_state == TX_IDLE);
  assign uart_tx_o       = r_tx;

  // TX FSM: line driven from a register so each level lasts exactly DIV cycles.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (inport_valid_i) begin
            r_tx_shift <= inport_data_i;
            r_tx       <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'(DATA_BITS - 1)) begin
              r_tx_idx   <= '0;
              r_tx       <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_idx   <= r_tx_idx + 1'b1;
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == 3'(STOP_BITS - 1)) begin
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_idx <= r_tx_idx + 1'b1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX path
  logic          r_rx_sync1;
  logic          r_rx_sync2;
  logic          r_rx_prev;
  rx_state_t     r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_idx;
  logic [7:0]    r_rx_shift;
  logic          w_rx_bit_end;
  logic          w_rx_push;
  logic          w_overflow;
  logic          r_rx_overflow;

  assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);
  // Push on the stop-bit sample cycle when the stop bit is valid.
  assign w_rx_push    = (r_rx_state == RX_STOP) & w_rx_bit_end & r_rx_sync2;

  // Two-flop synchroniser plus one history flop for start-edge detection;
  // all idle high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_sync1 <= uart_rx_i;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
    end
  end

  // RX FSM: mid-bit sampling anchored on the start edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_sync2) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == BIT_HALF) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_state <= r_rx_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
            if (r_rx_idx == 3'(DATA_BITS - 1)) begin
              r_rx_state <= RX_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_sync2 ? RX_IDLE : RX_WAIT_HIGH;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (r_rx_sync2) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------- RX buffer
`ifdef USB_UART_RXFIFO_EN
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_pop;

  assign w_pop           = ~w_fifo_empty & outport_accept_i;
  assign outport_valid_o = ~w_fifo_empty;
  assign w_overflow      = w_rx_push & w_fifo_full & ~w_pop;

  usb_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .push_i  (w_rx_push),
    .data_i  (r_rx_shift),
    .pop_i   (w_pop),
    .data_o  (outport_data_o),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );
`else
  logic       r_hold_valid;
  logic [7:0] r_hold_data;

  assign outport_valid_o = r_hold_valid;
  assign outport_data_o  = r_hold_data;
  assign w_overflow      = w_rx_push & r_hold_valid & ~outport_accept_i;

  // Single holding register; a push is taken when empty or being drained.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_rx_push && (!r_hold_valid || outport_accept_i)) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= r_rx_shift;
    end else if (outport_accept_i) begin
      r_hold_valid <= 1'b0;
    end
  end
`endif

  // Dropped-byte indication, registered to give a clean one-cycle pulse.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_rx_overflow <= 1'b0;
    else        r_rx_overflow <= w_overflow;
  end

  assign rx_overflow_o = r_rx_overflow;

endmodule

// File: tb/tb_usb_uart_bridge.sv
// Directed self-checking bench for usb_uart_bridge at 60 MHz / 1 Mbaud
// (60 clocks per bit). Covers both RX buffer builds (USB_UART_RXFIFO_EN).
module tb_usb_uart_bridge;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       inport_valid_i = 1'b0;
  logic [7:0] inport_data_i = 8'h00;
  logic       inport_accept_o;
  logic       outport_valid_o;
  logic [7:0] outport_data_o;
  logic       outport_accept_i = 1'b0;
  logic       uart_tx_o;
  logic       uart_rx_i = 1'b1;
  logic       rx_overflow_o;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned ovf_pulses  = 0;
  int unsigned ovf_base;
  int          first_c;

  localparam int BIT_CYC = 60;

  usb_uart_bridge #(
    .CLK_FREQ   (60000000),
    .BAUDRATE   (1000000),
    .FIFO_DEPTH (16)
  ) dut (
    .clk_i            (clk_i),
    .rst_n            (rst_n),
    .inport_valid_i   (inport_valid_i),
    .inport_data_i    (inport_data_i),
    .inport_accept_o  (inport_accept_o),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_accept_i (outport_accept_i),
    .uart_tx_o        (uart_tx_o),
    .uart_rx_i        (uart_rx_i),
    .rx_overflow_o    (rx_overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Count overflow pulse cycles, sampled away from the active edge.
  always @(negedge clk_i) if (rx_overflow_o) ovf_pulses++;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Hand one byte to TX and check every cycle of the 10-bit frame plus the
  // accept recovery on cycle 601. Call right after a negedge.
  task automatic send_tx_and_check(input logic [7:0] b, input string tag);
    logic [9:0] frame;
    logic       seen;
    logic       acc_seen;
    frame = {1'b1, b, 1'b0};
    check({tag, " accept before"}, 32'(inport_accept_o), 32'd1);
    inport_valid_i = 1'b1;
    inport_data_i  = b;
    @(negedge clk_i);
    inport_valid_i = 1'b0;
    seen = 1'b0;
    acc_seen = 1'b0;
    for (int k = 0; k < 10 * BIT_CYC; k++) begin
      if (k % BIT_CYC == 0) begin
        seen     = frame[k / BIT_CYC];
        acc_seen = 1'b0;
      end
      if (uart_tx_o !== frame[k / BIT_CYC]) seen = uart_tx_o;
      if (inport_accept_o !== 1'b0) acc_seen = inport_accept_o;
      if (k % BIT_CYC == BIT_CYC - 1) begin
        check($sformatf("%s bit%0d level", tag, k / BIT_CYC), 32'(seen),
              32'(frame[k / BIT_CYC]));
        check($sformatf("%s bit%0d accept", tag, k / BIT_CYC), 32'(acc_seen), 32'd0);
      end
      @(negedge clk_i);
    end
    check({tag, " accept cycle 601"}, 32'(inport_accept_o), 32'd1);
    check({tag, " line idle"}, 32'(uart_tx_o), 32'd1);
  endtask

  // Drive one 8N1 frame on uart_rx_i (changes on negedges). Reports the
  // stop-bit cycle index at which outport_valid_o was first seen high.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit,
                         output int first_valid);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    first_valid = -1;
    for (int bit_i = 0; bit_i < 10; bit_i++) begin
      uart_rx_i = frame[bit_i];
      for (int c = 0; c < BIT_CYC; c++) begin
        @(negedge clk_i);
        if (bit_i == 9 && first_valid < 0 && outport_valid_o) first_valid = c;
      end
    end
  endtask

  task automatic pulse_accept();
    outport_accept_i = 1'b1;
    @(negedge clk_i);
    outport_accept_i = 1'b0;
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk_i);
    check("reset tx", 32'(uart_tx_o), 32'd1);
    check("reset accept", 32'(inport_accept_o), 32'd1);
    check("reset out valid", 32'(outport_valid_o), 32'd0);
    check("reset out data", 32'(outport_data_o), 32'h00);
    check("reset overflow", 32'(rx_overflow_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);

    // TX 0xA5: 0,1,0,1,0,0,1,0,1,1.
    send_tx_and_check(8'hA5, "tx a5");

    // RX 0x3C: push ~3 cycles after the stop midpoint (cycle 30 of stop bit).
    send_rx(8'h3C, 1'b1, first_c);
    check($sformatf("rx 3c valid latency c=%0d", first_c),
          32'(first_c inside {[30:33]}), 32'd1);
    check("rx 3c valid", 32'(outport_valid_o), 32'd1);
    check("rx 3c data", 32'(outport_data_o), 32'h3C);
    repeat (50) @(negedge clk_i);
    check("rx 3c held valid", 32'(outport_valid_o), 32'd1);
    check("rx 3c held data", 32'(outport_data_o), 32'h3C);
    pulse_accept();
    check("rx 3c drained", 32'(outport_valid_o), 32'd0);

    // Glitch: 20 low cycles is rejected at the start-bit midpoint.
    uart_rx_i = 1'b0;
    repeat (20) @(negedge clk_i);
    uart_rx_i = 1'b1;
    repeat (100) @(negedge clk_i);
    check("glitch no byte", 32'(outport_valid_o), 32'd0);
    check("glitch no overflow", ovf_pulses, 32'd0);

    // Framing error: 0x55 with low stop bit, then line held low 200 cycles.
    send_rx(8'h55, 1'b0, first_c);
    repeat (200) @(negedge clk_i);
    check("framing err no byte", 32'(outport_valid_o), 32'd0);
    uart_rx_i = 1'b1;
    repeat (20) @(negedge clk_i);
    send_rx(8'h12, 1'b1, first_c);
    check("after framing valid", 32'(outport_valid_o), 32'd1);
    check("after framing data", 32'(outport_data_o), 32'h12);
    pulse_accept();
    check("after framing drained", 32'(outport_valid_o), 32'd0);

    // Overflow with nothing draining the buffer.
    ovf_base = ovf_pulses;
`ifdef USB_UART_RXFIFO_EN
    for (int i = 1; i <= 17; i++) send_rx(8'(i), 1'b1, first_c);
    repeat (5) @(negedge clk_i);
    check("fifo overflow pulses", ovf_pulses - ovf_base, 32'd1);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("fifo read %0d valid", i), 32'(outport_valid_o), 32'd1);
      check($sformatf("fifo read %0d data", i), 32'(outport_data_o), 32'(i));
      pulse_accept();
    end
    check("fifo empty after reads", 32'(outport_valid_o), 32'd0);
`else
    send_rx(8'h01, 1'b1, first_c);
    send_rx(8'h02, 1'b1, first_c);
    repeat (5) @(negedge clk_i);
    check("hold overflow pulses", ovf_pulses - ovf_base, 32'd1);
    check("hold keeps valid", 32'(outport_valid_o), 32'd1);
    check("hold keeps first byte", 32'(outport_data_o), 32'h01);
    pulse_accept();
    check("hold drained", 32'(outport_valid_o), 32'd0);
`endif

    // Reset mid-frame: a buffered RX byte is pending and TX is in frame bit 4.
    send_rx(8'h77, 1'b1, first_c);
    check("pre-reset rx pending", 32'(outport_valid_o), 32'd1);
    inport_valid_i = 1'b1;
    inport_data_i  = 8'h3C;
    @(negedge clk_i);
    inport_valid_i = 1'b0;
    repeat (4 * BIT_CYC + 30) @(negedge clk_i);
    check("pre-reset tx busy", 32'(inport_accept_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid-frame reset tx", 32'(uart_tx_o), 32'd1);
    check("mid-frame reset accept", 32'(inport_accept_o), 32'd1);
    check("mid-frame reset out valid", 32'(outport_valid_o), 32'd0);
    check("mid-frame reset out data", 32'(outport_data_o), 32'h00);
    repeat (5) @(negedge clk_i);
    check("reset held tx", 32'(uart_tx_o), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_i);
    send_tx_and_check(8'h0F, "tx 0f after reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
